// File: rtl/ffe_pkg.sv
// Shared constants and state encoding for the FFE coefficient path
// (ffe_coeff_writer and ffe_controller).
package ffe_pkg;

  localparam int FFE_DEPTH      = 4;
  localparam int FFE_COEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_SWAP_PEND = 2'd2
  } ffe_wr_state_e;

endpackage

// File: rtl/ffe_coeff_writer.sv
// Streams one coefficient set into the shadow bank of a ping-pong coefficient
// memory and swaps banks on the next FFE frame boundary.
module ffe_coeff_writer
  import ffe_pkg::*;
#(
  parameter int DEPTH      = FFE_DEPTH,
  parameter int COEF_WIDTH = FFE_COEF_WIDTH,
  parameter int ADDR_SIZE  = $clog2(DEPTH)
) (
  input  logic                  ffe_clk,
  input  logic                  rst,
  input  logic                  coef_valid,
  input  logic [COEF_WIDTH-1:0] coef_data,
  input  logic                  coef_last,
  output logic                  coef_ready,
  input  logic                  shift_en,
  input  logic                  rd_en,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_SIZE-1:0]  wr_addr,
  output logic [COEF_WIDTH-1:0] wr_data,
  output logic                  active_bank,
  output logic                  coef_updated,
  output logic                  coef_err
);

  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(DEPTH - 1);

  ffe_wr_state_e         state_q, state_d;
  logic [ADDR_SIZE-1:0]  cnt_q, cnt_d;
  logic                  active_q, active_d;
  logic                  ready_q, ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [COEF_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  upd_q, upd_d;
  logic                  err_q, err_d;

  logic accept;
  logic at_last_idx;

  assign accept      = coef_valid & ready_q;
  assign at_last_idx = (cnt_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE, S_WRITE: begin
        if (accept) begin
          // coef_last must coincide exactly with the final tap index
          if (coef_last != at_last_idx) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = coef_data;
            if (at_last_idx) begin
              cnt_d   = '0;
              state_d = S_SWAP_PEND;
            end else begin
              cnt_d   = cnt_q + ADDR_SIZE'(1);
              state_d = S_WRITE;
            end
          end
        end
      end
      S_SWAP_PEND: begin
        // only evaluated from the edge after the last write, so the final
        // write always lands in the shadow bank before it becomes active
        if (shift_en || !rd_en) begin
          active_d = ~active_q;
          upd_d    = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d != S_SWAP_PEND);
  end

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
    end
  end

  assign coef_ready   = ready_q;
  assign wr_en        = wr_en_q;
  assign wr_bank      = ~active_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign active_bank  = active_q;
  assign coef_updated = upd_q;
  assign coef_err     = err_q;

endmodule

// File: tb/tb_ffe_coeff_writer.sv
// Scoreboard bench for ffe_coeff_writer: a set-level reference model queues
// expected writes, swaps and framing errors; a negedge monitor consumes them.
module tb_ffe_coeff_writer;

  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int AW    = 2;

  logic          ffe_clk = 1'b0;
  logic          rst = 1'b1;
  logic          coef_valid = 1'b0;
  logic [CW-1:0] coef_data = '0;
  logic          coef_last = 1'b0;
  logic          shift_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          coef_ready, wr_en, wr_bank, active_bank, coef_updated, coef_err;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;

  always #5 ffe_clk = ~ffe_clk;

  ffe_coeff_writer #(.DEPTH(DEPTH), .COEF_WIDTH(CW), .ADDR_SIZE(AW)) dut (
    .ffe_clk(ffe_clk), .rst(rst),
    .coef_valid(coef_valid), .coef_data(coef_data), .coef_last(coef_last),
    .coef_ready(coef_ready), .shift_en(shift_en), .rd_en(rd_en),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .active_bank(active_bank), .coef_updated(coef_updated), .coef_err(coef_err)
  );

  typedef struct { bit bank; int addr; int data; } wr_t;

  wr_t exp_wr[$];
  bit  exp_upd[$];
  bit  exp_err[$];
  int  checks = 0;
  int  passes = 0;

  // reference model: beats collected so far, pending swap, reader bank
  int  m_set[$];
  bit  m_up = 1'b0;
  bit  m_pend = 1'b0;
  bit  m_active = 1'b0;
  int  shift_mode = 0;   // 0: never, 1: every 4th cycle, 2: random
  bit  rd_cfg = 1'b0;
  int  cyc_n = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic void fail_evt(string name);
    checks++;
    $display("FAIL %s: event seen, none expected", name);
  endfunction

  function automatic void model_edge(bit acc, int d, bit l, bit sh, bit rd);
    int idx;
    if (!m_up) begin
      m_up = 1'b1;
    end else if (m_pend) begin
      if (sh || !rd) begin
        m_active = !m_active;
        m_pend   = 1'b0;
        exp_upd.push_back(m_active);
      end
    end else if (acc) begin
      idx = m_set.size();
      if (l != (idx == DEPTH - 1)) begin
        exp_err.push_back(1'b1);
        m_set.delete();
      end else begin
        exp_wr.push_back('{bank: !m_active, addr: idx, data: d});
        m_set.push_back(d);
        if (idx == DEPTH - 1) begin
          m_set.delete();
          m_pend = 1'b1;
        end
      end
    end
  endfunction

  task automatic step(input bit v, input logic [CW-1:0] d, input bit l, output bit acc);
    bit sh;
    @(negedge ffe_clk);
    case (shift_mode)
      1:       sh = (cyc_n % 4 == 3);
      2:       sh = ($urandom_range(0, 3) == 0);
      default: sh = 1'b0;
    endcase
    cyc_n++;
    coef_valid = v; coef_data = d; coef_last = l; shift_en = sh; rd_en = rd_cfg;
    chk("coef_ready", coef_ready, int'(m_up && !m_pend));
    acc = v && m_up && !m_pend;
    @(posedge ffe_clk);
    model_edge(acc, d, l, sh, rd_cfg);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, '0, 1'b0, acc);
  endtask

  task automatic beat(input logic [CW-1:0] d, input bit l);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 40) begin
      step(1'b1, d, l, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      $display("FAIL beat_timeout: beat 0x%0h not accepted in %0d cycles", d, n);
    end
  endtask

  task automatic full_set();
    for (int i = 0; i < DEPTH; i++) beat(CW'($urandom), i == DEPTH - 1);
  endtask

  task automatic do_reset();
    @(negedge ffe_clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_active_bank", active_bank, 0);
    chk("rst_coef_ready", coef_ready, 0);
    chk("rst_coef_updated", coef_updated, 0);
    chk("rst_coef_err", coef_err, 0);
    chk("rst_pending_events", exp_wr.size() + exp_upd.size() + exp_err.size(), 0);
    exp_wr.delete(); exp_upd.delete(); exp_err.delete();
    m_set.delete();
    m_up = 1'b0; m_pend = 1'b0; m_active = 1'b0;
    coef_valid = 1'b0; shift_en = 1'b0;
    repeat (2) @(negedge ffe_clk);
    rst = 1'b1;
    @(posedge ffe_clk);
    m_up = 1'b1;
  endtask

  // monitor: consumes expected events whenever the DUT presents one
  always @(negedge ffe_clk) begin
    wr_t w;
    bit  b;
    chk("active_bank", active_bank, m_active);
    chk("wr_bank", wr_bank, !active_bank);
    if (wr_en) begin
      if (exp_wr.size() == 0) fail_evt("unexpected_wr_en");
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", wr_addr, w.addr);
        chk("wr_data", wr_data, w.data);
        chk("wr_bank_of_write", wr_bank, w.bank);
      end
    end
    if (coef_err) begin
      if (exp_err.size() == 0) fail_evt("unexpected_coef_err");
      else b = exp_err.pop_front();
    end
    if (coef_updated) begin
      if (exp_upd.size() == 0) fail_evt("unexpected_coef_updated");
      else begin
        b = exp_upd.pop_front();
        chk("bank_after_swap", active_bank, b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    // initial reset: falling edge needed to trigger the async clear
    #2 rst = 1'b0;
    #1;
    chk("init_wr_en", wr_en, 0);
    chk("init_active_bank", active_bank, 0);
    chk("init_coef_ready", coef_ready, 0);
    chk("init_coef_updated", coef_updated, 0);
    chk("init_coef_err", coef_err, 0);
    repeat (2) @(negedge ffe_clk);
    rst = 1'b1;
    @(posedge ffe_clk);
    m_up = 1'b1;

    // rd_en low: swap right after the last write
    rd_cfg = 1'b0; shift_mode = 0;
    beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 1);
    idle(4);

    // compute active: swap waits for shift_en every 4 cycles
    rd_cfg = 1'b1; shift_mode = 1;
    full_set();
    idle(8);

    // early coef_last, then a clean set from address 0
    rd_cfg = 1'b0; shift_mode = 0;
    beat(8'hA1, 0); beat(8'hA2, 1);
    idle(2);
    full_set();
    idle(3);

    // missing coef_last on the final beat
    beat(8'hB1, 0); beat(8'hB2, 0); beat(8'hB3, 0); beat(8'hB4, 0);
    idle(3);

    // reset mid-set, then a full set into bank 1
    beat(8'hC1, 0); beat(8'hC2, 0);
    do_reset();
    full_set();
    idle(3);

    // valid held through the swap-pending window
    rd_cfg = 1'b1; shift_mode = 0;
    full_set();
    repeat (6) step(1'b1, 8'hD0, 1'b0, acc);
    rd_cfg = 1'b0;
    beat(8'hD0, 0); beat(8'hD1, 0); beat(8'hD2, 0); beat(8'hD3, 1);
    idle(3);

    // randomized sets with occasional framing errors
    shift_mode = 2;
    for (int s = 0; s < 30; s++) begin
      rd_cfg = 1'($urandom_range(0, 1));
      for (int i = 0; i < DEPTH; i++) begin
        bit l = (i == DEPTH - 1);
        if ($urandom_range(0, 9) == 0) l = !l;
        beat(CW'($urandom), l);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end

    rd_cfg = 1'b0;
    idle(6);
    chk("left_wr", exp_wr.size(), 0);
    chk("left_upd", exp_upd.size(), 0);
    chk("left_err", exp_err.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
